// File: rtl/repeat_pattern_checker.sv
// Self-check sink for periodic pattern sources: learns one period of the stream,
// then tracks lock, per-sample mismatches and a saturating mismatch count.
module repeat_pattern_checker #(
  parameter int unsigned WIDTH      = 3,
  parameter int unsigned PERIOD     = 2,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned MISS_LIMIT = 3,
  localparam int unsigned PH_W      = (PERIOD > 1) ? $clog2(PERIOD) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             locked,
  output logic             err,
  output logic [15:0]      err_count,
  output logic [PH_W-1:0]  phase
);

  localparam int unsigned MC_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned MS_W = $clog2(MISS_LIMIT + 1);
  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(PERIOD - 1);
  localparam logic [PH_W-1:0] PH_RELRN = PH_W'(1 % PERIOD);

  typedef enum logic [1:0] {
    LEARN  = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [PH_W-1:0]  phase_n, phase_inc, wr_idx;
  logic [MC_W-1:0]  match_cnt, match_n;
  logic [MS_W-1:0]  miss_cnt, miss_n;
  logic             locked_n, err_n, wr_en, hit, relearn;
  logic [15:0]      err_count_n;
  logic [WIDTH-1:0] pat [PERIOD];

  assign phase_inc = (phase == PH_LAST) ? '0 : phase + 1'b1;
  assign hit       = (in_data == pat[phase]);

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= LEARN;
      phase     <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      match_cnt <= match_n;
      miss_cnt  <= miss_n;
      locked    <= locked_n;
      err       <= err_n;
      err_count <= err_count_n;
    end
  end

  // Pattern buffer; contents are don't-care after reset so it carries no reset
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) pat[wr_idx] <= in_data;
  end

  // Next-state, counters and buffer write control
  always_comb begin
    state_n     = state;
    phase_n     = phase;
    match_n     = match_cnt;
    miss_n      = miss_cnt;
    locked_n    = locked;
    err_n       = 1'b0;
    err_count_n = err_count;
    wr_en       = 1'b0;
    wr_idx      = phase;
    relearn     = 1'b0;

    if (in_valid) begin
      phase_n = phase_inc;
      case (state)
        LEARN: begin
          wr_en = 1'b1;
          if (phase == PH_LAST) begin
            state_n = CHECK;
            match_n = '0;
          end
        end
        CHECK: begin
          if (hit) begin
            match_n = match_cnt + 1'b1;
            if (match_cnt == MC_W'(LOCK_CNT - 1)) begin
              state_n  = LOCKED;
              locked_n = 1'b1;
              miss_n   = '0;
            end
          end else begin
            relearn = 1'b1;
          end
        end
        LOCKED: begin
          if (hit) begin
            miss_n = '0;
          end else begin
            err_n  = 1'b1;
            miss_n = miss_cnt + 1'b1;
            if (err_count != 16'hFFFF) err_count_n = err_count + 16'd1;
            if (miss_cnt == MS_W'(MISS_LIMIT - 1)) begin
              locked_n = 1'b0;
              relearn  = 1'b1;
            end
          end
        end
        default: state_n = LEARN;
      endcase

      // Relearn restarts the period with the current sample as entry 0
      if (relearn) begin
        wr_en   = 1'b1;
        wr_idx  = '0;
        phase_n = PH_RELRN;
        match_n = '0;
        miss_n  = '0;
        state_n = (PERIOD == 1) ? CHECK : LEARN;
      end
    end
  end

endmodule

// File: tb/tb_repeat_pattern_checker.sv
// Bench for repeat_pattern_checker: directed scenarios plus a randomized stream,
// each checked against a queue-based behavioural model of the checker.
module tb_repeat_pattern_checker;

  localparam int unsigned WIDTH      = 3;
  localparam int unsigned PERIOD     = 2;
  localparam int unsigned LOCK_CNT   = 4;
  localparam int unsigned MISS_LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [2:0]  in_data;
  logic        locked;
  logic        err;
  logic [15:0] err_count;
  logic [0:0]  phase;
  logic [18:0] obs;

  int checks = 0;
  int errors = 0;

  // Behavioural model: learned samples in a queue, plain integer counters
  logic [2:0] m_pat[$];
  int         m_phase, m_matches, m_misses, m_cnt;
  bit         m_locked, m_err;

  repeat_pattern_checker #(
    .WIDTH(WIDTH), .PERIOD(PERIOD), .LOCK_CNT(LOCK_CNT), .MISS_LIMIT(MISS_LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .locked(locked), .err(err), .err_count(err_count), .phase(phase)
  );

  always #5 clk = ~clk;
  assign obs = {locked, err, err_count, phase};

  function automatic void model_reset();
    m_pat.delete();
    m_phase = 0; m_matches = 0; m_misses = 0; m_cnt = 0;
    m_locked = 0; m_err = 0;
  endfunction

  function automatic void model_step(input bit v, input logic [2:0] d);
    bit relearn = 0;
    m_err = 0;
    if (!v) return;
    if (m_pat.size() < PERIOD) begin
      m_pat.push_back(d);
    end else if (d == m_pat[m_phase]) begin
      if (m_locked) m_misses = 0;
      else begin
        m_matches++;
        if (m_matches == LOCK_CNT) begin m_locked = 1; m_misses = 0; end
      end
    end else if (m_locked) begin
      m_err = 1;
      if (m_cnt < 65535) m_cnt++;
      m_misses++;
      if (m_misses == MISS_LIMIT) begin m_locked = 0; relearn = 1; end
    end else begin
      relearn = 1;
    end
    if (relearn) begin
      m_pat.delete();
      m_pat.push_back(d);
      m_matches = 0;
      m_phase = 1 % PERIOD;
    end else begin
      m_phase = (m_phase + 1) % PERIOD;
    end
  endfunction

  function automatic logic [18:0] model_w();
    return {m_locked, m_err, 16'(m_cnt), 1'(m_phase)};
  endfunction

  function automatic logic [2:0] good();
    return m_pat[m_phase];
  endfunction

  task automatic drive(input bit v, input logic [2:0] d);
    in_valid = v;
    in_data  = d;
    model_step(v, d);
    @(posedge clk); #1;
  endtask

  // Reset with a valid sample in flight; the reset must win
  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 3'($urandom);
    model_reset();
    @(posedge clk); #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== 19'h0) begin
      errors++; $display("FAIL reset_state got %h exp %h", obs, 19'h0);
    end
    drive(1'b0, 3'd5);
    checks++;
    if (obs !== model_w()) begin
      errors++; $display("FAIL reset_idle got %h exp %h", obs, model_w());
    end
  endtask

  task automatic test_lock();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, (k % 2) ? 3'd7 : 3'd0);
      checks++;
      if (obs !== model_w()) begin
        errors++; $display("FAIL lock_model k=%0d got %h exp %h", k, obs, model_w());
      end
      checks++;
      if (locked !== 1'(k >= 5) || phase !== 1'((k + 1) % 2) || err !== 1'b0) begin
        errors++;
        $display("FAIL lock_point k=%0d got l=%b p=%b e=%b exp l=%b p=%b e=0",
                 k, locked, phase, err, 1'(k >= 5), 1'((k + 1) % 2));
      end
    end
  endtask

  task automatic test_single_error();
    logic [15:0] c0 = err_count;
    drive(1'b1, good() ^ 3'd5);
    checks++;
    if (err !== 1'b1 || err_count !== c0 + 16'd1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL single_err got e=%b c=%0d l=%b exp e=1 c=%0d l=1", err, err_count, locked, c0 + 16'd1);
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, good());
      checks++;
      if (obs !== model_w() || err !== 1'b0) begin
        errors++; $display("FAIL single_after k=%0d got %h exp %h", k, obs, model_w());
      end
    end
  endtask

  task automatic test_phase_slip();
    logic [15:0] c0 = err_count;
    logic [2:0]  x = good();
    logic [2:0]  y = good() ^ 3'd7;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, (i % 2 == 0) ? y : x);
      checks++;
      if (err !== 1'(i < 3) || locked !== 1'(i < 2 || i >= 7) ||
          err_count !== c0 + 16'((i < 3) ? i + 1 : 3)) begin
        errors++;
        $display("FAIL slip i=%0d got e=%b l=%b c=%0d exp e=%b l=%b c=%0d", i, err, locked,
                 err_count, 1'(i < 3), 1'(i < 2 || i >= 7), c0 + 16'((i < 3) ? i + 1 : 3));
      end
      checks++;
      if (obs !== model_w()) begin
        errors++; $display("FAIL slip_model i=%0d got %h exp %h", i, obs, model_w());
      end
    end
  endtask

  task automatic test_sparse();
    int j = 0;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      if (k % 2 == 0) begin
        drive(1'b1, (j % 2) ? 3'd7 : 3'd0);
        j++;
      end else begin
        drive(1'b0, 3'($urandom));
      end
      checks++;
      if (locked !== 1'(j >= 6) || phase !== 1'(j % 2) || err !== 1'b0 || obs !== model_w()) begin
        errors++;
        $display("FAIL sparse k=%0d got %h exp %h lockexp=%b", k, obs, model_w(), 1'(j >= 6));
      end
    end
  endtask

  task automatic test_prelock();
    logic [2:0] seq [10] = '{3'd0, 3'd7, 3'd0, 3'd3, 3'd0, 3'd3, 3'd0, 3'd3, 3'd0, 3'd3};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, seq[i]);
      checks++;
      if (locked !== 1'(i >= 8) || err !== 1'b0 || err_count !== 16'd0 ||
          (i == 3 && phase !== 1'b1) || obs !== model_w()) begin
        errors++;
        $display("FAIL prelock i=%0d got %h exp %h lockexp=%b", i, obs, model_w(), 1'(i >= 8));
      end
    end
  endtask

  task automatic test_reset_mid();
    test_lock();
    for (int e = 0; e < 2; e++) begin
      drive(1'b1, good() ^ 3'd2);
      drive(1'b1, good());
      drive(1'b1, good());
    end
    checks++;
    if (err_count !== 16'd2 || locked !== 1'b1) begin
      errors++; $display("FAIL mid_setup got c=%0d l=%b exp c=2 l=1", err_count, locked);
    end
    do_reset();
    checks++;
    if (obs !== 19'h0) begin
      errors++; $display("FAIL mid_reset got %h exp %h", obs, 19'h0);
    end
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, (k % 2) ? 3'd7 : 3'd0);
      checks++;
      if (locked !== 1'(k >= 5) || obs !== model_w()) begin
        errors++; $display("FAIL mid_relock k=%0d got %h exp %h", k, obs, model_w());
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        logic [2:0] d;
        if (m_pat.size() == PERIOD && $urandom_range(0, 7) != 0) d = good();
        else d = 3'($urandom);
        drive($urandom_range(0, 3) != 0, d);
      end
      checks++;
      if (obs !== model_w()) begin
        errors++; $display("FAIL random k=%0d got %h exp %h", k, obs, model_w());
      end
    end
  endtask

  // Preloads the count near the top so saturation is reached in a few cycles
  task automatic test_saturation();
    test_lock();
    force dut.err_count = 16'hFFF8;
    #1 release dut.err_count;
    m_cnt = 16'hFFF8;
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, good() ^ 3'd1);
      checks++;
      if (err !== 1'b1 || locked !== 1'b1 || obs !== model_w()) begin
        errors++; $display("FAIL sat_miss k=%0d got %h exp %h", k, obs, model_w());
      end
      drive(1'b1, good());
      checks++;
      if (err !== 1'b0 || obs !== model_w()) begin
        errors++; $display("FAIL sat_match k=%0d got %h exp %h", k, obs, model_w());
      end
    end
    checks++;
    if (err_count !== 16'hFFFF) begin
      errors++; $display("FAIL sat_hold got %h exp ffff", err_count);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 3'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_lock();
    test_single_error();
    test_phase_slip();
    test_sparse();
    test_prelock();
    test_reset_mid();
    test_random();
    test_saturation();
    in_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
